// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART state encoding and baud divider derivation
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Clocks per bit; uart_tx uses the same formula so both ends agree on baud.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

  function automatic int unsigned baud_half(input int unsigned clk_hz, input int unsigned sclk_hz);
    return baud_div(clk_hz, sclk_hz) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for asynchronous pins
// RESET_VAL lets idle-high lines (UART) and idle-low lines (buttons) share it.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a valid/ready holding register
// Framing errors, overruns and rejected start bits are reported as one-cycle pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 40000000,
  parameter int unsigned SCLK_HZ       = 115200,
  parameter int unsigned COUNTER_WIDTH = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       start_glitch
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, SCLK_HZ);
  localparam int unsigned HALF = baud_half(CLK_HZ, SCLK_HZ);
  localparam logic [COUNTER_WIDTH-1:0] DIV_LAST  = COUNTER_WIDTH'(DIV - 1);
  localparam logic [COUNTER_WIDTH-1:0] HALF_LAST = COUNTER_WIDTH'(HALF - 1);
  localparam bit CNT_FITS = (longint'(DIV) - 1) < (longint'(1) << COUNTER_WIDTH);

  logic                     rxd_s;
  uart_state_e              state_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [2:0]               idx_q;
  logic [7:0]               shift_q;
  logic                     done_q;
  logic [7:0]               data_q;
  logic                     valid_q;
  logic                     ferr_q;
  logic                     ovr_q;
  logic                     glitch_q;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      glitch_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) state_q <= ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rxd_s) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
            end else begin
              glitch_q <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxd_s;
            if (idx_q == 3'd7) state_q <= ST_STOP;
            else               idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaving at the stop midpoint leaves half a bit to catch a back-to-back start.
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxd_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // A same-cycle accept frees the holding register, so the new byte wins.
      if (done_q) begin
        if (!valid_q || out_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (CNT_FITS);
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign start_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a bit-timing reference model
module tb_uart_rx;

  localparam int DIV  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_error;
  logic       overrun;
  logic       start_glitch;

  uart_rx #(.CLK_HZ(16), .SCLK_HZ(1), .COUNTER_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .start_glitch (start_glitch)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         gl_cnt = 0;
  int         vcyc = 0;
  int         cyc = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_error)  fe_cnt++;
      if (overrun)      ov_cnt++;
      if (start_glitch) gl_cnt++;
      if (out_valid) vcyc++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", int'(out_data), 256);
        else                   check("rx_byte", int'(out_data), int'(exp_q.pop_front()));
      end
    end
    prev_valid = out_valid;
  end

  // Line cycle c after the start edge carries frame bit c/p; the receiver samples
  // data bit j at c = HALF + DIV*(j+1) and the stop bit at j = 8.
  function automatic logic [8:0] model(input logic [7:0] b, input logic stop, input int p,
                                       input logic tail);
    logic [10:0] line;
    logic [8:0]  r;
    int          k;
    line = {tail, stop, b, 1'b0};
    for (int j = 0; j < 9; j++) begin
      k = (HALF + DIV * (j + 1)) / p;
      r[j] = (k > 10) ? tail : line[k];
    end
    return r;
  endfunction

  task automatic clear_counts();
    fe_cnt = 0; ov_cnt = 0; gl_cnt = 0; vcyc = 0;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int p, input int nbits);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = bits[i];
      repeat (p) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int p, input int gap, inout int exp_fe);
    logic [8:0] m;
    m = model(b, 1'b1, p, 1'b1);
    if (m[8]) exp_q.push_back(m[7:0]);
    else      exp_fe++;
    send(b, 1'b1, p, 10);
    idle(gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int efe;
    int t0;
    logic [8:0] m;

    repeat (3) begin @(posedge clk); #1; end
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_pulses", int'({frame_error, overrun, start_glitch}), 0);
    reset = 1'b0;
    idle(10);

    // Exact-timing 0x55, with latency from the start edge to out_valid.
    clear_counts(); efe = 0;
    t0 = cyc;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, DIV, 10);
    idle(20);
    drain();
    check("t1_valid_cycles", vcyc, 1);
    check("t1_latency", rise_cyc - t0, 1 + HALF + 9 * DIV + 3);
    check("t1_pulses", fe_cnt + ov_cnt + gl_cnt, 0);

    // Overrun: two back-to-back frames while the consumer stalls.
    clear_counts();
    out_ready = 1'b0;
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b1, DIV, 10);
    send(8'h3C, 1'b1, DIV, 10);
    idle(20);
    check("t2_held_valid", int'(out_valid), 1);
    check("t2_held_data", int'(out_data), 8'hA3);
    check("t2_overrun_count", ov_cnt, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_valid_drop", int'(out_valid), 0);
    check("t2_queue", exp_q.size(), 0);

    // Framing error followed by a long break, then a clean byte.
    clear_counts();
    send(8'hFF, 1'b0, DIV, 10);
    uart_rxd = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    idle(30);
    check("t3_frame_error_count", fe_cnt, 1);
    check("t3_no_valid", vcyc, 0);
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, DIV, 10);
    idle(20);
    drain();
    check("t3_after_break_fe", fe_cnt, 1);

    // Short glitch on an idle line, then confirm the receiver still works.
    clear_counts();
    uart_rxd = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    idle(30);
    check("t4_glitch_count", gl_cnt, 1);
    check("t4_no_valid", vcyc, 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, DIV, 10);
    idle(20);
    drain();
    check("t4_glitch_total", gl_cnt, 1);

    // Baud skew on 0x81.
    clear_counts(); efe = 0;
    send_byte(8'h81, 15, 20, efe);
    send_byte(8'h81, 17, 20, efe);
    drain();
    check("t5_fe", fe_cnt, efe);
    m = model(8'h81, 1'b1, 17, 1'b1);
    check("t5_model_17", int'(m), 9'h181);

    // Reset during bit 4 of a frame.
    send(8'hC3, 1'b1, DIV, 5);
    uart_rxd = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_reset_valid", int'(out_valid), 0);
    check("t6_reset_data", int'(out_data), 0);
    check("t6_reset_pulses", int'({frame_error, overrun, start_glitch}), 0);
    reset = 1'b0;
    clear_counts();
    idle(40);
    check("t6_no_partial", vcyc, 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, DIV, 10);
    idle(20);
    drain();

    // Randomized frames with skew and idle gaps.
    clear_counts(); efe = 0;
    for (int i = 0; i < 24; i++) begin
      send_byte(8'($urandom_range(0, 255)), 15 + int'($urandom_range(0, 2)),
                int'($urandom_range(4, 20)), efe);
    end
    drain();
    check("rand_frame_errors", fe_cnt, efe);
    check("rand_overruns", ov_cnt, 0);
    check("rand_glitches", gl_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the sc1_soc UART port; the counterpart to the SoC's transmit path.
- Takes the asynchronous board pin uart_rxd, recovers bytes by mid-bit sampling from a free-running bit-period counter, and presents each byte to the CPU-side register logic through a valid/ready holding register.
- Reports framing errors, overruns and glitch-rejected starts as one-cycle pulses.

Parameters:
- CLK_HZ, 40000000, clk frequency in Hz.
- SCLK_HZ, 115200, baud rate.
- COUNTER_WIDTH, 9, width of bit-period counter; must hold CLK_HZ/SCLK_HZ - 1.
- Derived localparams: DIV = CLK_HZ/SCLK_HZ (integer division; 347 at defaults), HALF = DIV/2 (173).

Ports:
- clk  input  1  system clock (the SoC clk domain).
- reset  input  1  synchronous, active-high reset.
- uart_rxd  input  1  asynchronous serial line; idles high.
- out_data  output  8  received byte; stable while out_valid=1.
- out_valid  output  1  byte available.
- out_ready  input  1  consumer accepts the byte when out_valid & out_ready.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte completed while the holding register was still full.
- start_glitch  output  1  one-cycle pulse: start bit rejected at its mid-point.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE, counter = 0, shift register = 0.
  - Both synchronizer flops = 1 (line idles high, so reset does not produce a false start).
  - out_data = 0, out_valid = 0, all pulses = 0.
- Reset mid-frame: the partial byte is discarded. A held byte is also cleared (out_valid -> 0).
- Synchronizer: 2 flops; rxd_s = uart_rxd delayed 2 cycles. All decisions below use rxd_s.
- FSM:
  - IDLE: counter = 0. When rxd_s = 0, go to START.
  - START: counter counts 0..HALF-1.
    - At HALF-1, if rxd_s = 0: go to DATA, counter = 0, bit index = 0.
    - Otherwise: pulse start_glitch, go to IDLE.
  - DATA: counter counts 0..DIV-1. At DIV-1, shift rxd_s into bit[index] (LSB first) and reset counter. After index 7, go to STOP.
  - STOP: at counter DIV-1, sample rxd_s.
    - 1: deliver the byte, go to IDLE. IDLE is re-entered at the stop-bit midpoint so a back-to-back start is caught.
    - 0: pulse frame_error, drop the byte, go to BREAK.
  - BREAK: wait for rxd_s = 1, then go to IDLE. A held-low line (break) produces exactly one frame_error.
- Delivery (cycle after the stop sample):
  - If out_valid = 0: out_data <= byte, out_valid <= 1.
  - If out_valid = 1 and out_ready = 0 that cycle: the new byte is discarded, overrun pulses, old data is kept.
  - If out_valid = 1 and out_ready = 1 in the same cycle as delivery: the accept wins, the new byte is loaded, out_valid stays 1, no overrun.
- Handshake: out_valid falls the cycle after a cycle with out_valid & out_ready. out_ready while out_valid = 0 is ignored.
- Latency: out_valid rises 2 (synchronizer) + 1 cycles after the stop-bit mid-sample point on uart_rxd.
- Counter never wraps past DIV-1; width is checked by a simulation-only assertion (DIV-1 < 2**COUNTER_WIDTH).

Decomposition:
- Shared package / include: FSM state encodings (IDLE, START, DATA, STOP, BREAK) and the DIV/HALF derivation function, so that the future uart_tx shares the identical baud formula.
- Natural sub-module: uart_sync2, the 2-flop synchronizer with parameterized reset value. It is reused for PB inputs.
- Everything else stays in a single uart_rx.

Test Plan (bench uses CLK_HZ=16, SCLK_HZ=1, so DIV=16, HALF=8; out_ready=1 unless stated):
- Send 0x55 with exact timing -> out_data=0x55, out_valid high 1 cycle, no error pulses.
- Hold out_ready=0, send 0xA3 then 0x3C back-to-back -> out_data stays 0xA3, overrun pulses once; raising out_ready then drops out_valid next cycle.
- Send 0xFF with stop bit driven 0, then hold low 40 cycles, then high -> exactly one frame_error pulse, no out_valid; a following 0x12 is received correctly.
- 4-cycle low glitch on idle line -> start_glitch pulses once, no byte, FSM back in IDLE.
- Baud skew: send 0x81 with bit period 15 and then 17 cycles -> 0x81 received both times.
- Assert reset during bit 4 of a frame -> all outputs 0 next cycle; the next full frame 0x7E is received correctly.
